// File: rtl/miriscv_arb_pkg.sv
// Shared types and constants for the miriscv RAM arbiter.
package miriscv_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_RESP} arb_state_t;
    typedef enum logic {REQ_INSTR, REQ_DATA} arb_owner_t;

    localparam logic [3:0] ARB_BE_FULL = 4'b1111;

endpackage

// File: rtl/miriscv_arb_pick2.sv
// Two-way winner selection between fetch and LSU.
// MIRISCV_ARB_RR_EN defined: round-robin with a last-grant register.
// MIRISCV_ARB_RR_EN undefined: fixed priority, DATA beats INSTR.
module miriscv_arb_pick2
    import miriscv_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       instr_req_i,
    input  logic       data_req_i,
    input  logic       grant_i,
    output arb_owner_t winner_o
);

`ifdef MIRISCV_ARB_RR_EN
    arb_owner_t last_q;

    // On contention the requester not granted last wins.
    always_comb begin
        winner_o = REQ_INSTR;
        if (instr_req_i && data_req_i)
            winner_o = (last_q == REQ_INSTR) ? REQ_DATA : REQ_INSTR;
        else if (data_req_i)
            winner_o = REQ_DATA;
    end

    // Remember who won each grant; reset to INSTR so first contention goes to DATA.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            last_q <= REQ_INSTR;
        else if (grant_i)
            last_q <= winner_o;
    end
`else
    // Fixed priority needs no history; clock, reset and grant are not consumed.
    logic unused_pick;
    assign unused_pick = clk_i ^ rst_i ^ grant_i ^ instr_req_i;

    // DATA always beats INSTR.
    always_comb begin
        winner_o = data_req_i ? REQ_DATA : REQ_INSTR;
    end
`endif

endmodule

// File: rtl/miriscv_mem_arbiter.sv
// Shares the single-port program/data RAM between fetch and LSU.
// Three-state access sequence IDLE -> GRANT -> RESP with registered mem_* outputs.
// Arbitration policy selected by MIRISCV_ARB_RR_EN (see miriscv_arb_pick2).
module miriscv_mem_arbiter
    import miriscv_arb_pkg::*;
#(
    parameter  int RAM_SIZE = 4096,
    localparam int AW       = $clog2(RAM_SIZE)
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          instr_req_i,
    input  logic [31:0]   instr_addr_i,
    output logic          instr_ack_o,
    output logic [31:0]   instr_rdata_o,
    output logic          instr_err_o,

    input  logic          data_req_i,
    input  logic          data_we_i,
    input  logic [3:0]    data_be_i,
    input  logic [31:0]   data_addr_i,
    input  logic [31:0]   data_wdata_i,
    output logic          data_ack_o,
    output logic [31:0]   data_rdata_o,
    output logic          data_err_o,

    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [3:0]    mem_be_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i
);

    arb_state_t  state_q;
    arb_owner_t  owner_q;
    logic        err_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [3:0]  mem_be_q;
    logic [AW-1:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    arb_owner_t  winner;
    logic        any_req;
    logic        grant;
    logic        sel_data;
    logic [31:0] sel_addr;
    logic        sel_oor;
    logic        sel_we;
    logic [3:0]  sel_be;

    assign any_req = instr_req_i | data_req_i;
    assign grant   = (state_q == ARB_IDLE) && any_req;

    miriscv_arb_pick2 u_pick (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .instr_req_i (instr_req_i),
        .data_req_i  (data_req_i),
        .grant_i     (grant),
        .winner_o    (winner)
    );

    // Winner's request fields and range check; fetch is always a full-word read.
    always_comb begin
        sel_data = (winner == REQ_DATA);
        sel_addr = sel_data ? data_addr_i : instr_addr_i;
        sel_oor  = (sel_addr >> (AW + 2)) != 32'd0;
        sel_we   = sel_data & data_we_i;
        sel_be   = sel_we ? data_be_i : ARB_BE_FULL;
    end

    // Byte offset bits never address the word-wide RAM.
    logic unused_addr;
    assign unused_addr = ^sel_addr[1:0];

    // Access sequencer: latch winner in IDLE, drive RAM for one cycle in GRANT, ack in RESP.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ARB_IDLE;
            owner_q     <= REQ_INSTR;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (any_req) begin
                        state_q     <= ARB_GRANT;
                        owner_q     <= winner;
                        err_q       <= sel_oor;
                        // Out-of-range accesses never touch the RAM.
                        mem_req_q   <= ~sel_oor;
                        mem_we_q    <= sel_we & ~sel_oor;
                        mem_be_q    <= sel_be;
                        mem_addr_q  <= sel_addr[AW+1:2];
                        mem_wdata_q <= sel_data ? data_wdata_i : 32'd0;
                    end
                end
                ARB_GRANT: begin
                    state_q   <= ARB_RESP;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
                ARB_RESP: begin
                    state_q <= ARB_IDLE;
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_be_o    = mem_be_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    // Responses decode from RESP and the owner; RAM data passes through unless errored.
    always_comb begin
        instr_ack_o   = (state_q == ARB_RESP) && (owner_q == REQ_INSTR);
        data_ack_o    = (state_q == ARB_RESP) && (owner_q == REQ_DATA);
        instr_err_o   = instr_ack_o & err_q;
        data_err_o    = data_ack_o & err_q;
        instr_rdata_o = (instr_ack_o && !err_q) ? mem_rdata_i : 32'd0;
        data_rdata_o  = (data_ack_o && !err_q) ? mem_rdata_i : 32'd0;
    end

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Directed bench for miriscv_mem_arbiter with a behavioural 4096-word RAM.
module tb_miriscv_mem_arbiter;

    localparam int RAM_SIZE = 4096;
    localparam int AW = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_ack_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_ack_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    miriscv_mem_arbiter #(.RAM_SIZE(RAM_SIZE)) dut (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_ack_o(instr_ack_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_ack_o(data_ack_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    // Synchronous RAM model: preload on the first edge, then byte-enabled write / registered read.
    logic [31:0] ram [0:RAM_SIZE-1];
    logic        ram_init_done = 1'b0;
    always @(posedge clk) begin
        if (!ram_init_done) begin
            for (int i = 0; i < RAM_SIZE; i++) ram[i] <= 32'h1000_0000 | i;
            ram[4]    <= 32'hDEAD_BEEF;
            ram[8]    <= 32'hCAFE_F00D;
            ram[4095] <= 32'h0BAD_F00D;
            ram_init_done <= 1'b1;
        end else if (mem_req_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) ram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end
            mem_rdata_i <= ram[mem_addr_o];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    typedef struct {
        logic        is_data;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [11:0] exp_idx;
        logic        chk_rdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [13];

    task automatic idle_inputs();
        instr_req_i = 0; instr_addr_i = 0;
        data_req_i = 0; data_we_i = 0; data_be_i = 0; data_addr_i = 0; data_wdata_i = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " outs"},
              {31'd0, instr_ack_o | instr_err_o | data_ack_o | data_err_o | mem_req_o | mem_we_o},
              32'd0);
        check({tag, " mem_bus"}, {16'd0, mem_be_o, mem_addr_o} | mem_wdata_o, 32'd0);
        check({tag, " rdata"}, instr_rdata_o | data_rdata_o, 32'd0);
    endtask

    task automatic reset_pulse();
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
    endtask

    initial begin
        int      acks;
        int      last_k;
        logic    seen;
        logic    got_data;
        logic [3:0] exp_be;

        rst = 1;
        idle_inputs();

        //                 data we  be       addr          wdata         err idx   chk rdata
        vecs[0]  = '{1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'h0,         1'b0, 12'd4,    1'b1, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b1, 1'b1, 4'h3, 32'h0000_0020, 32'h1234_5678, 1'b0, 12'd8,    1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0020, 32'h0,         1'b0, 12'd8,    1'b1, 32'hCAFE_5678};
        vecs[3]  = '{1'b1, 1'b0, 4'h0, 32'h0000_4000, 32'h0,         1'b1, 12'd0,    1'b1, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0,         1'b1, 12'd0,    1'b1, 32'h0};
        vecs[5]  = '{1'b0, 1'b0, 4'h0, 32'h0000_3FFE, 32'h0,         1'b0, 12'd4095, 1'b1, 32'h0BAD_F00D};
        vecs[6]  = '{1'b1, 1'b1, 4'hF, 32'h0000_3FFC, 32'h55AA_55AA, 1'b0, 12'd4095, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, 4'h0, 32'h0000_3FFC, 32'h0,         1'b0, 12'd4095, 1'b1, 32'h55AA_55AA};
        vecs[8]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0013, 32'h0,         1'b0, 12'd4,    1'b1, 32'hDEAD_BEEF};
        vecs[9]  = '{1'b1, 1'b1, 4'hC, 32'h0000_0024, 32'hAABB_CCDD, 1'b0, 12'd9,    1'b0, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 4'h0, 32'h0000_0024, 32'h0,         1'b0, 12'd9,    1'b1, 32'hAABB_0009};
        vecs[11] = '{1'b1, 1'b1, 4'hF, 32'h8000_0020, 32'hFFFF_FFFF, 1'b1, 12'd0,    1'b1, 32'h0};
        vecs[12] = '{1'b0, 1'b0, 4'h0, 32'h0000_0020, 32'h0,         1'b0, 12'd8,    1'b1, 32'hCAFE_5678};

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 0;

        // Single accesses from the table
        for (int v = 0; v < 13; v++) begin
            @(negedge clk);
            if (vecs[v].is_data) begin
                data_req_i = 1; data_we_i = vecs[v].we; data_be_i = vecs[v].be;
                data_addr_i = vecs[v].addr; data_wdata_i = vecs[v].wdata;
            end else begin
                instr_req_i = 1; instr_addr_i = vecs[v].addr;
            end
            exp_be = (vecs[v].is_data && vecs[v].we) ? vecs[v].be : 4'hF;
            @(negedge clk);
            check($sformatf("v%0d mem_req", v), {31'd0, mem_req_o}, {31'd0, ~vecs[v].exp_err});
            check($sformatf("v%0d ack_early", v), {31'd0, instr_ack_o | data_ack_o}, 32'd0);
            if (!vecs[v].exp_err) begin
                check($sformatf("v%0d mem_addr", v), {20'd0, mem_addr_o}, {20'd0, vecs[v].exp_idx});
                check($sformatf("v%0d mem_we", v), {31'd0, mem_we_o}, {31'd0, vecs[v].we});
                check($sformatf("v%0d mem_be", v), {28'd0, mem_be_o}, {28'd0, exp_be});
                if (vecs[v].we)
                    check($sformatf("v%0d mem_wdata", v), mem_wdata_o, vecs[v].wdata);
            end
            @(negedge clk);
            check($sformatf("v%0d mem_req_drop", v), {31'd0, mem_req_o}, 32'd0);
            if (vecs[v].is_data) begin
                check($sformatf("v%0d ack", v), {30'd0, data_ack_o, instr_ack_o}, 32'd2);
                check($sformatf("v%0d err", v), {31'd0, data_err_o}, {31'd0, vecs[v].exp_err});
                if (vecs[v].chk_rdata)
                    check($sformatf("v%0d rdata", v), data_rdata_o, vecs[v].exp_rdata);
            end else begin
                check($sformatf("v%0d ack", v), {30'd0, data_ack_o, instr_ack_o}, 32'd1);
                check($sformatf("v%0d err", v), {31'd0, instr_err_o}, {31'd0, vecs[v].exp_err});
                if (vecs[v].chk_rdata)
                    check($sformatf("v%0d rdata", v), instr_rdata_o, vecs[v].exp_rdata);
            end
            idle_inputs();
        end

        // Continuous contention for four grants
        reset_pulse();
        @(negedge clk);
        instr_req_i = 1; instr_addr_i = 32'h10;
        data_req_i = 1; data_we_i = 0; data_addr_i = 32'h20;
        for (int g = 0; g < 4; g++) begin
            seen = 0; got_data = 0;
            for (int c = 0; c < 6 && !seen; c++) begin
                @(negedge clk);
                if (instr_ack_o || data_ack_o) begin
                    seen = 1; got_data = data_ack_o;
                end
            end
            if (!seen) begin
                check($sformatf("contend g%0d timeout", g), 32'd0, 32'd1);
            end else begin
`ifdef MIRISCV_ARB_RR_EN
                check($sformatf("contend g%0d owner", g), {31'd0, got_data}, {31'd0, (g % 2) == 0});
`else
                check($sformatf("contend g%0d owner", g), {31'd0, got_data}, 32'd1);
`endif
                check($sformatf("contend g%0d rdata", g), got_data ? data_rdata_o : instr_rdata_o,
                      got_data ? 32'hCAFE_5678 : 32'hDEAD_BEEF);
            end
        end
        idle_inputs();

        // Reset asserted during GRANT drops the access; held request is re-served
        @(negedge clk);
        @(negedge clk);
        instr_req_i = 1; instr_addr_i = 32'h10;
        @(negedge clk);
        check("rstmid grant", {31'd0, mem_req_o}, 32'd1);
        rst = 1;
        #1;
        check_all_zero("rstmid async");
        @(negedge clk);
        check("rstmid no_ack", {31'd0, instr_ack_o}, 32'd0);
        rst = 0;
        #1;
        check("rstmid release", {31'd0, instr_ack_o | mem_req_o}, 32'd0);
        @(negedge clk);
        check("rstmid regrant", {31'd0, mem_req_o}, 32'd1);
        check("rstmid ack_early", {31'd0, instr_ack_o}, 32'd0);
        @(negedge clk);
        check("rstmid ack", {31'd0, instr_ack_o}, 32'd1);
        check("rstmid rdata", instr_rdata_o, 32'hDEAD_BEEF);
        idle_inputs();

        // Request held into the cycle after RESP starts exactly one extra access
        @(negedge clk);
        instr_req_i = 1; instr_addr_i = 32'h10;
        acks = 0; last_k = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (instr_ack_o) begin
                acks++; last_k = k;
            end
            if (k == 4) instr_req_i = 0;
        end
        check("held ack_count", acks, 32'd2);
        check("held second_ack_cycle", last_k, 32'd5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
